// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential binary-to-BCD converter, one input bit per clock (double dabble)
// Optional BIN2BCD_SAT_EN: an over-range result is loaded as all nines instead of value mod 10^DIGITS.
module bin2bcd_seq #(
  parameter int DATA_W = 36,
  parameter int DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [BW-1:0]     r_work;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;

  logic [BW-1:0]     w_adj;
  logic              w_carry;
  logic [BW-1:0]     w_work_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic [BW-1:0]     w_result;

  always_comb begin
    w_adj = r_work;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_work[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is a 10^DIGITS carry; dropping it keeps value mod 10^DIGITS.
  assign {w_carry, w_work_nxt, w_data_nxt} = {w_adj, r_data, 1'b0};

`ifdef BIN2BCD_SAT_EN
  assign w_result = r_ovf ? {DIGITS{4'h9}} : r_work;
`else
  assign w_result = r_work;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_data  <= data;
            r_work  <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_work_nxt;
          r_data <= w_data_nxt;
          r_ovf  <= r_ovf | w_carry;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CW'(DATA_W - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          bcd     <= w_result;
          ovf     <= r_ovf;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized and directed checks of bin2bcd_seq against an arithmetic model
module tb_bin2bcd_seq;

  localparam int DATA_W = 36;
  localparam int DIGITS = 9;
  localparam longint unsigned LIM = 64'd1000000000;
  localparam int LAT = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data = '0;
  logic              busy;
  logic              done;
  logic [4*DIGITS-1:0] bcd;
  logic              ovf;

  int n_cmp = 0;
  int n_mis = 0;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] ref_bcd(input longint unsigned v);
    longint unsigned m;
    logic [35:0] r;
    m = v % LIM;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef BIN2BCD_SAT_EN
    if (v >= LIM) r = {DIGITS{4'h9}};
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the DUT idle.
  task automatic run_conv(input longint unsigned v, input string tag);
    int lat;
    int busy_cnt;
    logic [35:0] held;
    start = 1'b1;
    data  = DATA_W'(v);
    tick();
    start = 1'b0;
    data  = DATA_W'({$urandom, $urandom});
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (busy) busy_cnt++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(LAT));
    check({tag, "_busycyc"}, 64'(busy_cnt), 64'(LAT));
    check({tag, "_bcd"}, 64'(bcd), 64'(ref_bcd(v)));
    check({tag, "_ovf"}, 64'(ovf), 64'(v >= LIM));
    held = bcd;
    tick();
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(bcd), 64'(held));
  endtask

  initial begin
    int first_done;
    int n_done;
    int lat;
    logic [35:0] bcd_first;
    longint unsigned v;

    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    run_conv(0, "zero");
    run_conv(123456789, "dig1");
    run_conv(999999999, "dig9");
    run_conv(1000000000, "ovf");
    run_conv(64'hFFFFFFFFF, "max");

    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) v = longint'($urandom_range(999999999, 0));
      else v = {28'd0, 4'($urandom), $urandom};
      run_conv(v, "rand");
    end

    // start held for 40 edges; data changes mid-conversion
    start = 1'b1;
    data  = 36'd42;
    first_done = -1;
    n_done = 0;
    bcd_first = '0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 10) data = 36'd99;
      if (done) begin
        n_done++;
        if (first_done < 0) begin
          first_done = c;
          bcd_first = bcd;
        end
      end
      if (c == 38) check("hold_reaccept", 64'(busy), 64'd1);
    end
    start = 1'b0;
    check("hold_ndone", 64'(n_done), 64'd1);
    check("hold_first", 64'(first_done), 64'(LAT));
    check("hold_bcd", 64'(bcd_first), 64'h42);
    lat = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    check("hold_second_seen", 64'(done), 64'd1);
    check("hold_second_bcd", 64'(bcd), 64'h99);
    tick();

    // reset mid-conversion, with start asserted alongside reset
    start = 1'b1;
    data  = 36'd5;
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_bcd", 64'(bcd), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (done) n_done++;
    end
    check("midrst_nodone", 64'(n_done), 64'd0);
    run_conv(7, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter DATA_W SHALL be declared: default 36; binary input width, legal range 4..64.
REQ-002 Parameter DIGITS SHALL be declared: default 9; number of BCD output digits, legal range 1..16.
REQ-003 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be: input, 1 bit, reset; synchronous, active-high.
REQ-005 Port start SHALL be: input, 1 bit, request a conversion of data; sampled only in IDLE.
REQ-006 Port data SHALL be: input, DATA_W bits, unsigned binary value; captured on the accepting edge.
REQ-007 Port busy SHALL be: output, 1 bit, high while a conversion is in progress.
REQ-008 Port done SHALL be: output, 1 bit, one-cycle pulse marking the update of bcd/ovf.
REQ-009 Port bcd SHALL be: output, 4*DIGITS bits, packed result; digit 0 (units) in [3:0], digit k in [4k+3:4k].
REQ-010 Port ovf SHALL be: output, 1 bit, high when the last converted value was >= 10^DIGITS.

Function
REQ-011 The block SHALL use shift-and-add-3 (double dabble) with one input bit per cycle.
REQ-012 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-013 IDLE SHALL move to SHIFT on a rising edge where start=1, capturing data and clearing the working BCD register, bit counter and overflow flag.
REQ-014 In SHIFT, each edge SHALL add 3 to every working digit >= 5, then shift the {digits, data} chain left 1 bit, MSB of data first.
REQ-015 SHIFT SHALL last exactly DATA_W edges and then move to DONE.
REQ-016 A 1 shifted out of the top working digit SHALL set a sticky overflow flag; the working digits therefore hold value mod 10^DIGITS.
REQ-017 DONE SHALL last one edge: it loads bcd and ovf, pulses done, and returns to IDLE.
REQ-018 For start accepted at edge N, bcd, ovf and done SHALL change at edge N+DATA_W+1; done SHALL be high for exactly that one cycle.
REQ-019 busy SHALL be high from edge N through edge N+DATA_W+1, and low in IDLE.
REQ-020 start while busy=1 SHALL be ignored (no queueing); start in the cycle done=1 SHALL be accepted.
REQ-021 bcd and ovf SHALL hold their values between done pulses; data changes after capture SHALL have no effect.
REQ-022 Every bcd digit SHALL always be in the range 0..9.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, busy=0, done=0, bcd=0 and ovf=0, clearing all internal registers.
REQ-024 rst SHALL take priority over start, and a conversion interrupted by rst SHALL produce no done pulse.

Configuration
REQ-025 Macro BIN2BCD_SAT_EN SHALL control saturation on over-range input.
REQ-026 With BIN2BCD_SAT_EN defined, DONE SHALL load all digits = 9 when the overflow flag is set.
REQ-027 Without BIN2BCD_SAT_EN, DONE SHALL load value mod 10^DIGITS.
REQ-028 ovf SHALL behave identically in both builds.

Verification (DATA_W=36, DIGITS=9)
REQ-029 Scenario zero: rst then start with data=0 at edge N -> done only at N+37; bcd=0, ovf=0; busy high N..N+37.
REQ-030 Scenario digits: data=123456789 -> bcd=36'h123456789, ovf=0; data=999999999 -> bcd=36'h999999999, ovf=0.
REQ-031 Scenario overflow: data=1000000000 -> ovf=1; bcd=36'h999999999 with BIN2BCD_SAT_EN, else 36'h000000000.
REQ-032 Scenario max value: data=36'hFFFFFFFFF (68719476735) -> ovf=1; bcd=36'h999999999 with macro, else 36'h719476735.
REQ-033 Scenario start handling: start=1 held for 40 cycles with data=42 -> one conversion with bcd=36'h42; re-accepted at the done cycle; data changed mid-conversion does not alter the result.
REQ-034 Scenario reset mid-conversion: rst at N+10 -> busy=0, bcd=0, no done; a new start with data=7 -> bcd=36'h7 after 37 cycles.
